sram_arbiter: RTL and testbench

//  Shares one sram_controller between two requesters (e.g. host port and DMA/scrub engine).

---
 rtl/sram_arbiter.sv | 112 +++++++++++
 tb/tb_sram_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin front end that shares one sram_controller between
// two requesters. It issues a single rd/wr pulse, holds address and data until
// the controller reports ready, then returns rdata with a one-cycle done pulse.
// Optional WAIT-state timeout: define SRAM_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module sram_arbiter #(
  parameter int AW      = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      req_valid,
  input  logic [1:0]      req_wr,
  input  logic [2*AW-1:0] req_addr,
  input  logic [2*DW-1:0] req_wdata,
  output logic [1:0]      req_ack,
  output logic [1:0]      done,
  output logic [DW-1:0]   rdata,
  output logic            err,
  output logic            busy,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ready
);

  typedef enum logic [1:0] {IDLE, CMD, WAIT} state_t;

  state_t state;
  logic   last_grant;  // requester granted most recently
  logic   owner;       // requester owning the outstanding transaction
  logic   cur_wr;      // outstanding transaction is a write
  logic   win;
  logic   tmo;

  // Pick the winner: a lone requester wins, otherwise the one not granted last
  always_comb begin
    win = 1'b0;
    if (req_valid == 2'b11) win = ~last_grant;
    else                    win = req_valid[1];
  end

`ifdef SRAM_ARB_TIMEOUT_EN
  localparam logic [7:0] TLIM = 8'(TIMEOUT - 1);
  logic [7:0] tcnt;

  // WAIT-cycle counter: zero on WAIT entry, +1 per WAIT cycle; the limit
  // fires during the TIMEOUT-th WAIT cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              tcnt <= '0;
    else if (state != WAIT)  tcnt <= '0;
    else                     tcnt <= tcnt + 8'd1;
  end

  assign tmo = (tcnt == TLIM);
`else
  assign tmo = 1'b0;
`endif

  // Arbitration FSM; every output is a register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      cur_wr     <= 1'b0;
      req_ack    <= '0;
      done       <= '0;
      rdata      <= '0;
      err        <= 1'b0;
      busy       <= 1'b0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      req_ack <= '0;
      done    <= '0;
      err     <= 1'b0;
      mem_rd  <= 1'b0;
      mem_wr  <= 1'b0;
      case (state)
        IDLE: if (|req_valid) begin
          owner      <= win;
          last_grant <= win;
          cur_wr     <= req_wr[win];
          req_ack    <= win ? 2'b10 : 2'b01;
          mem_wr     <= req_wr[win];
          mem_rd     <= ~req_wr[win];
          mem_addr   <= win ? req_addr[2*AW-1:AW]  : req_addr[AW-1:0];
          mem_wdata  <= win ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
          busy       <= 1'b1;
          state      <= CMD;
        end
        CMD: state <= WAIT;
        WAIT: if (mem_ready || tmo) begin
          // mem_ready beats a coincident timeout
          done  <= owner ? 2'b10 : 2'b01;
          if (mem_ready && !cur_wr) rdata <= mem_rdata;
          err   <= ~mem_ready;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: a behavioural SRAM controller answers
// commands after a chosen latency; a transaction-level model predicts winner,
// latencies, rdata and err. Timeout cases compile in with SRAM_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_sram_arbiter;
  localparam int AW = 4, DW = 8, TO = 15;

  logic clk = 1'b0, reset = 1'b0;
  logic [1:0]      req_valid = '0, req_wr = '0;
  logic [2*AW-1:0] req_addr = '0;
  logic [2*DW-1:0] req_wdata = '0;
  logic [1:0]      req_ack, done;
  logic [DW-1:0]   rdata, mem_wdata;
  logic            err, busy, mem_rd, mem_wr;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_rdata = '0;
  logic            mem_ready = 1'b0;

  int checks = 0, errors = 0;

  sram_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ack(req_ack), .done(done),
    .rdata(rdata), .err(err), .busy(busy), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // Behavioural controller: answers a command ctl_lat negedges after it is
  // seen (0 = never). spur drives mem_ready high outside WAIT to show it is ignored.
  logic [DW-1:0] cmem [16];
  int            ctl_lat = 1;
  bit            spur = 0, inited = 0, pend = 0, pwr = 0;
  int            cnt = 0;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwd;
  always @(negedge clk) begin
    if (!reset) begin
      pend = 0; mem_ready = 1'b0;
      if (!inited) begin
        for (int i = 0; i < 16; i++) cmem[i] = DW'(i * 17 + 3);
        inited = 1;
      end
    end else begin
      mem_ready = 1'b0;
      if (pend) begin
        if (cnt == 1) begin
          mem_ready = 1'b1; pend = 0;
          if (pwr) begin cmem[paddr] = pwd; mem_rdata = DW'($urandom); end
          else mem_rdata = cmem[paddr];
        end else if (cnt > 1) cnt--;
      end else if (spur) mem_ready = 1'b1;
      if (mem_rd || mem_wr) begin
        pend = 1; cnt = ctl_lat; paddr = mem_addr; pwr = mem_wr; pwd = mem_wdata;
        if (spur) mem_ready = 1'b1;
      end
    end
  end

  // Reference model state
  logic [DW-1:0] smem [16];
  int            lastg = 1;
  logic [DW-1:0] last_rd = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction: request vector v (fields already driven), controller
  // latency lat, keep = leave req_valid asserted, poke = r1 pulses valid in WAIT
  task automatic txn(input logic [1:0] v, input int lat, input bit keep, input bit poke);
    int w, n, exp_lat;
    bit wr, exp_err;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    w  = (v == 2'b11) ? (lastg == 0 ? 1 : 0) : (v[1] ? 1 : 0);
    a  = (w == 1) ? req_addr[2*AW-1:AW]  : req_addr[AW-1:0];
    wd = (w == 1) ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
    wr = req_wr[w];
    ctl_lat = lat;
    req_valid = v;
    n = 0;
    do begin @(negedge clk); n++; end while (req_ack == 2'b00 && n < 8);
    chk("ack_latency", n, 1);
    chk("ack", req_ack, (w == 1) ? 2 : 1);
    chk("cmd_wr", mem_wr, wr);
    chk("cmd_rd", mem_rd, !wr);
    chk("cmd_addr", mem_addr, a);
    chk("busy_cmd", busy, 1);
    if (wr) chk("cmd_wdata", mem_wdata, wd);
    lastg = w;
    if (!keep) req_valid = 2'b00;
    exp_err = 0; exp_lat = lat;
`ifdef SRAM_ARB_TIMEOUT_EN
    if (lat == 0 || lat > TO) begin exp_err = 1; exp_lat = TO; end
`endif
    n = 0;
    do begin
      @(negedge clk); n++;
      if (poke) req_valid[1] = (n < 3);
      if (done == 2'b00) begin
        chk("hold_addr", mem_addr, a);
        chk("no_pulse", {req_ack, mem_rd, mem_wr}, 0);
      end
    end while (done == 2'b00 && n < 40);
    chk("done_latency", n, exp_lat + 1);
    chk("done", done, (w == 1) ? 2 : 1);
    chk("err", err, exp_err);
    chk("busy_done", busy, 0);
    if (!exp_err) begin
      if (wr) smem[a] = wd;
      else    last_rd = smem[a];
    end
    chk("rdata", rdata, last_rd);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) smem[i] = DW'(i * 17 + 3);

    // Reset held with random inputs: every output stays 0
    for (int i = 0; i < 4; i++) begin
      req_valid = 2'($urandom); req_wr = 2'($urandom);
      req_addr = 8'($urandom); req_wdata = 16'($urandom);
      @(negedge clk);
      chk("reset_outs", {req_ack, done, rdata, err, busy, mem_rd, mem_wr, mem_addr, mem_wdata}, 0);
    end
    req_valid = 2'b00;
    #2 reset = 1'b1;
    @(negedge clk);
    chk("idle_ack", req_ack, 0);
    chk("idle_busy", busy, 0);

    // r0 write 5A to addr 4, then r1 reads it back
    req_wr = 2'b01; req_addr = {4'h0, 4'h4}; req_wdata = {8'h00, 8'h5A};
    txn(2'b01, 2, 0, 0);
    req_wr = 2'b00; req_addr = {4'h4, 4'h0};
    txn(2'b10, 3, 0, 0);
    chk("read_5A", rdata, 8'h5A);

    // mem_ready high during IDLE and CMD must not end the transaction early
    spur = 1;
    req_wr = 2'b00; req_addr = {4'h0, 4'h9};
    txn(2'b01, 3, 0, 0);
    spur = 0;

    // r1 pulses valid while r0 waits: withdrawn, never acked
    req_wr = 2'b01; req_addr = {4'h2, 4'h7}; req_wdata = {8'h11, 8'hC3};
    txn(2'b01, 5, 0, 1);
    @(negedge clk);
    chk("withdraw_ack", req_ack, 0);
    chk("withdraw_done", done, 0);

    // Reset mid-WAIT drops the transaction immediately
    req_wr = 2'b01; req_addr = {4'h0, 4'h3}; req_wdata = {8'h00, 8'hEE};
    ctl_lat = 10; req_valid = 2'b01;
    @(negedge clk);
    chk("pre_rst_ack", req_ack, 1);
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_mem", {mem_rd, mem_wr, mem_addr, mem_wdata}, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    chk("rst_done", done, 0);
    #2 reset = 1'b1;
    lastg = 1; last_rd = '0;
    @(negedge clk);

    // Both valid continuously: r0,r1,r0,r1 with ack right after each done
    req_wr = 2'b10; req_addr = {4'h4, 4'h3}; req_wdata = {8'hA5, 8'h3C};
    for (int t = 0; t < 4; t++) begin
      txn(2'b11, 1 + (t % 2), 1, 0);
      chk("rr_order", lastg, t % 2);
    end
    req_valid = 2'b00;
    @(negedge clk);

    // Randomised traffic
    for (int t = 0; t < 24; t++) begin
      req_wr = 2'($urandom); req_addr = 8'($urandom); req_wdata = 16'($urandom);
      txn(2'($urandom_range(1, 3)), $urandom_range(1, 4), 0, 0);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

`ifdef SRAM_ARB_TIMEOUT_EN
    // Controller silent: err after TIMEOUT WAIT cycles; ready at the limit wins
    req_wr = 2'b00; req_addr = {4'h0, 4'h5};
    txn(2'b01, 0, 0, 0);
    txn(2'b01, TO, 0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
